// File: rtl/md5_gidx_seq.sv
`default_nettype none
// ============================================================================
// Module   : md5_gidx_seq
// Purpose  : Step / round / message-word-index sequencer for an MD5 block.
//            Walks 4*WORDS steps per block, presenting step, round and g over
//            a valid/ready handshake with abort and a done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module md5_gidx_seq #(
  parameter int IDX_W = 4,
  parameter int MUL0  = 1,
  parameter int ADD0  = 0,
  parameter int MUL1  = 5,
  parameter int ADD1  = 1,
  parameter int MUL2  = 3,
  parameter int ADD2  = 5,
  parameter int MUL3  = 7,
  parameter int ADD3  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             ready,
  output logic             valid,
  output logic [IDX_W+1:0] step,
  output logic [1:0]       round,
  output logic [IDX_W-1:0] g,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam int SW = IDX_W + 2;   // step width
  localparam int PW = IDX_W + 3;   // product width before truncation

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_run  = 1'b1;

  localparam logic [SW-1:0]    c_last_step = SW'(4 * (2 ** IDX_W) - 1);
  localparam logic [SW-1:0]    c_step_one  = SW'(1);
  // Step 0 is round 0 with s = 0, so g reduces to the round-0 offset.
  localparam logic [IDX_W-1:0] c_g_first   = IDX_W'(ADD0);

  localparam logic [PW-1:0] c_mul0 = PW'(MUL0);
  localparam logic [PW-1:0] c_add0 = PW'(ADD0);
  localparam logic [PW-1:0] c_mul1 = PW'(MUL1);
  localparam logic [PW-1:0] c_add1 = PW'(ADD1);
  localparam logic [PW-1:0] c_mul2 = PW'(MUL2);
  localparam logic [PW-1:0] c_add2 = PW'(ADD2);
  localparam logic [PW-1:0] c_mul3 = PW'(MUL3);
  localparam logic [PW-1:0] c_add3 = PW'(ADD3);

  logic [0:0]       r_state;
  logic             r_valid;
  logic [SW-1:0]    r_step;
  logic [IDX_W-1:0] r_g;
  logic             r_last;
  logic             r_done;

  logic [SW-1:0]    w_step_inc;
  logic [IDX_W-1:0] w_g_inc;
  logic             w_last_inc;

  // Affine word index for a given step: (MUL_r * s + ADD_r) mod WORDS.
  function automatic logic [IDX_W-1:0] g_calc(input logic [SW-1:0] st);
    logic [PW-1:0] m;
    logic [PW-1:0] a;
    logic [PW-1:0] p;
    m = c_mul0;
    a = c_add0;
    case (st[SW-1:IDX_W])
      2'd0: begin m = c_mul0; a = c_add0; end
      2'd1: begin m = c_mul1; a = c_add1; end
      2'd2: begin m = c_mul2; a = c_add2; end
      default: begin m = c_mul3; a = c_add3; end
    endcase
    p = m * {3'b000, st[IDX_W-1:0]} + a;
    return p[IDX_W-1:0];
  endfunction

  // Precompute the outputs for the following step so they register together.
  always_comb begin
    w_step_inc = r_step + c_step_one;
    w_g_inc    = g_calc(w_step_inc);
    w_last_inc = (w_step_inc == c_last_step);
  end

  // Sequencer state and registered outputs; abort outranks acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_valid <= 1'b0;
      r_step  <= '0;
      r_g     <= c_g_first;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_state <= c_st_run;
            r_valid <= 1'b1;
            r_step  <= '0;
            r_g     <= c_g_first;
            r_last  <= 1'b0;
          end
        end
        default: begin
          if (abort) begin
            r_state <= c_st_idle;
            r_valid <= 1'b0;
            r_step  <= '0;
            r_g     <= c_g_first;
            r_last  <= 1'b0;
          end else if (ready) begin
            if (r_last) begin
              r_state <= c_st_idle;
              r_valid <= 1'b0;
              r_step  <= '0;
              r_g     <= c_g_first;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_step <= w_step_inc;
              r_g    <= w_g_inc;
              r_last <= w_last_inc;
            end
          end
        end
      endcase
    end
  end

  assign valid = r_valid;
  assign step  = r_step;
  assign round = r_step[SW-1:IDX_W];
  assign g     = r_g;
  assign last  = r_last;
  assign busy  = (r_state == c_st_run);
  assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_md5_gidx_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_md5_gidx_seq
// Purpose  : Directed self-checking bench for md5_gidx_seq (IDX_W=4 and 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_md5_gidx_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort, ready;
  logic       valid, last, busy, done;
  logic [5:0] step;
  logic [1:0] round;
  logic [3:0] g;

  logic       start3, abort3, ready3;
  logic       valid3, last3, busy3, done3;
  logic [4:0] step3;
  logic [1:0] round3;
  logic [2:0] g3;

  int vectors     = 0;
  int miscompares = 0;

  md5_gidx_seq dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .ready(ready),
    .valid(valid), .step(step), .round(round), .g(g), .last(last),
    .busy(busy), .done(done)
  );

  md5_gidx_seq #(.IDX_W(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .abort(abort3), .ready(ready3),
    .valid(valid3), .step(step3), .round(round3), .g(g3), .last(last3),
    .busy(busy3), .done(done3)
  );

  always #5 clk = ~clk;

  // Reference word index with the default coefficients.
  function automatic int gm(input int st, input int iw);
    int w, r, s, m, a;
    w = 1 << iw;
    r = st / w;
    s = st % w;
    case (r)
      0: begin m = 1; a = 0; end
      1: begin m = 5; a = 1; end
      2: begin m = 3; a = 5; end
      default: begin m = 7; a = 0; end
    endcase
    return (m * s + a) % w;
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 0; abort = 0; ready = 0;
    start3 = 0; abort3 = 0; ready3 = 0;
    #3;
    vectors++;
    if ({valid, busy, done, last} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got v/b/d/l=%b want 0000", {valid, busy, done, last});
    end
    vectors++;
    if (step !== 6'd0 || round !== 2'd0 || g !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_data: got step=%0d round=%0d g=%0d want 0/0/0", step, round, g);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got valid=%b busy=%b want 0 0", valid, busy);
    end
  endtask

  task automatic test_full_block();
    int exp;
    start = 1; ready = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 64; i++) begin
      vectors++;
      if (valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || step !== 6'(i)) begin
        miscompares++;
        $display("FAIL full_ctrl i=%0d: got v=%b b=%b d=%b step=%0d want 1 1 0 %0d",
                 i, valid, busy, done, step, i);
      end
      vectors++;
      if (round !== 2'(i / 16)) begin
        miscompares++;
        $display("FAIL full_round i=%0d: got %0d want %0d", i, round, i / 16);
      end
      vectors++;
      if (g !== 4'(gm(i, 4))) begin
        miscompares++;
        $display("FAIL full_g i=%0d: got %0d want %0d", i, g, gm(i, 4));
      end
      vectors++;
      if (last !== (i == 63)) begin
        miscompares++;
        $display("FAIL full_last i=%0d: got %b want %b", i, last, (i == 63));
      end
      case (i)
        16: exp = 1;  17: exp = 6;  31: exp = 12; 32: exp = 5;
        33: exp = 8;  48: exp = 0;  49: exp = 7;  63: exp = 9;
        default: exp = -1;
      endcase
      if (exp >= 0) begin
        vectors++;
        if (g !== 4'(exp)) begin
          miscompares++;
          $display("FAIL full_gspot step=%0d: got %0d want %0d", i, g, exp);
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || step !== 6'd0) begin
      miscompares++;
      $display("FAIL full_done: got d=%b v=%b b=%b step=%0d want 1 0 0 0",
               done, valid, busy, step);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL full_done_pulse: got done=%b want 0", done);
    end
  endtask

  task automatic test_stall();
    start = 1; ready = 1;
    @(negedge clk);
    start = 0;
    repeat (20) @(negedge clk);
    vectors++;
    if (step !== 6'd20) begin
      miscompares++;
      $display("FAIL stall_reach: got step=%0d want 20", step);
    end
    ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (valid !== 1'b1 || step !== 6'd20 || g !== 4'd5 || round !== 2'd1) begin
        miscompares++;
        $display("FAIL stall_hold k=%0d: got v=%b step=%0d g=%0d round=%0d want 1 20 5 1",
                 k, valid, step, g, round);
      end
    end
    ready = 1;
    @(negedge clk);
    vectors++;
    if (step !== 6'd21 || g !== 4'd10) begin
      miscompares++;
      $display("FAIL stall_resume: got step=%0d g=%0d want 21 10", step, g);
    end
    for (int k = 0; k < 60 && done !== 1'b1; k++) @(negedge clk);
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_done_timeout: got done=%b want 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    start = 1; ready = 1;
    @(negedge clk);
    start = 0;
    repeat (40) @(negedge clk);
    vectors++;
    if (step !== 6'd40) begin
      miscompares++;
      $display("FAIL abort_reach: got step=%0d want 40", step);
    end
    abort = 1;
    @(negedge clk);
    abort = 0;
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || step !== 6'd0) begin
      miscompares++;
      $display("FAIL abort_idle: got v=%b b=%b d=%b step=%0d want 0 0 0 0",
               valid, busy, done, step);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || valid !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_nodone k=%0d: got d=%b v=%b want 0 0", k, done, valid);
      end
    end
    start = 1;
    @(negedge clk);
    start = 0;
    vectors++;
    if (valid !== 1'b1 || step !== 6'd0 || g !== 4'd0) begin
      miscompares++;
      $display("FAIL abort_restart: got v=%b step=%0d g=%0d want 1 0 0", valid, step, g);
    end
    abort = 1;
    @(negedge clk);
    abort = 0;
  endtask

  task automatic test_back_to_back();
    int dones;
    dones = 0;
    start = 1; ready = 1;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      if (done === 1'b1) dones++;
      vectors++;
      if (step !== 6'(i) || valid !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_step i=%0d: got step=%0d v=%b want %0d 1", i, step, valid, i);
      end
      @(negedge clk);
    end
    if (done === 1'b1) dones++;
    vectors++;
    if (dones !== 1 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_done: got dones=%0d v=%b want 1 0", dones, valid);
    end
    @(negedge clk);
    start = 0;
    vectors++;
    if (valid !== 1'b1 || step !== 6'd0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_restart: got v=%b step=%0d d=%b want 1 0 0", valid, step, done);
    end
    abort = 1;
    @(negedge clk);
    abort = 0;
  endtask

  task automatic test_async_reset();
    start = 1; ready = 1;
    @(negedge clk);
    start = 0;
    repeat (35) @(negedge clk);
    vectors++;
    if (step !== 6'd35) begin
      miscompares++;
      $display("FAIL areset_reach: got step=%0d want 35", step);
    end
    #2 reset = 1;
    #1;
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || step !== 6'd0) begin
      miscompares++;
      $display("FAIL areset_immediate: got v=%b b=%b d=%b step=%0d want 0 0 0 0",
               valid, busy, done, step);
    end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_idle: got v=%b b=%b d=%b want 0 0 0", valid, busy, done);
    end
  endtask

  task automatic test_idx3();
    start3 = 1; ready3 = 1;
    @(negedge clk);
    start3 = 0;
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (valid3 !== 1'b1 || step3 !== 5'(i) || g3 !== 3'(gm(i, 3))) begin
        miscompares++;
        $display("FAIL idx3_seq i=%0d: got v=%b step=%0d g=%0d want 1 %0d %0d",
                 i, valid3, step3, g3, i, gm(i, 3));
      end
      vectors++;
      if (last3 !== (i == 31) || round3 !== 2'(i / 8)) begin
        miscompares++;
        $display("FAIL idx3_last i=%0d: got last=%b round=%0d want %b %0d",
                 i, last3, round3, (i == 31), i / 8);
      end
      if (i == 8 || i == 31) begin
        vectors++;
        if (g3 !== 3'd1) begin
          miscompares++;
          $display("FAIL idx3_gspot step=%0d: got %0d want 1", i, g3);
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (done3 !== 1'b1 || valid3 !== 1'b0) begin
      miscompares++;
      $display("FAIL idx3_done: got d=%b v=%b want 1 0", done3, valid3);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_stall();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_idx3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/md5_gidx_seq.md
Name: md5_gidx_seq

Overview:
- Sequential step/word-index generator for the MD5 compression core.
- On a start request it walks through all 4*WORDS steps of one block and emits, per step: step number, round number and message-word index g.
- The next output is presented over a valid/ready handshake so the round datapath can stall it.
- Generalises the fixed 16-word, fixed-coefficient g calculation to parametrised word count and per-round affine coefficients, with sequencing, stall, abort and done signalling.

Parameters:
- IDX_W, 4, log2 of words per block (WORDS = 2**IDX_W); g width.
- MUL0, 1, round-0 multiplier.
- ADD0, 0, round-0 offset.
- MUL1, 5, round-1 multiplier.
- ADD1, 1, round-1 offset.
- MUL2, 3, round-2 multiplier.
- ADD2, 5, round-2 offset.
- MUL3, 7, round-3 multiplier.
- ADD3, 0, round-3 offset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a block; sampled only in IDLE.
- abort  in  1  synchronous abandon of the current block.
- ready  in  1  consumer accepts the current output this cycle.
- valid  out  1  step/round/g outputs are valid.
- step  out  IDX_W+2  step number, 0 .. 4*WORDS-1.
- round  out  2  round number, equal to step[IDX_W+1:IDX_W].
- g  out  IDX_W  message word index for this step.
- last  out  1  current output is the final step (step == 4*WORDS-1).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last step is accepted.

Behaviour:
- Reset values: state=IDLE; valid=0, step=0, round=0, g=0 (ADD0 mod WORDS with defaults), last=0, busy=0, done=0.
- Reset is asynchronous. Asserting it mid-block returns to IDLE immediately; no done pulse is produced.
- States:
  - IDLE: start=1 -> RUN. At the next edge, valid=1, step=0, busy=1. Latency from start to first valid is 1 cycle.
  - RUN, valid && ready && !last: step increments by 1 and outputs update at the next edge. A step can be accepted every cycle (full throughput).
  - RUN, valid && !ready: all outputs hold stable (no change to step, round or g).
  - RUN, valid && ready && last: -> IDLE. At the next edge, valid=0, busy=0, done=1 for exactly one cycle, step returns to 0.
  - RUN, abort=1: -> IDLE at the next edge. valid=0, busy=0, no done. abort has priority over ready.
- start is ignored while busy (no restart, no effect on step). start and done may coincide: start in the done cycle (state is IDLE) begins a new block.
- g arithmetic:
  - s = step[IDX_W-1:0]; r = round.
  - g = (MUL_r * s + ADD_r) mod 2**IDX_W, truncated to IDX_W bits; the product is computed at width IDX_W+3 and then truncated.
  - g is registered alongside step, so all outputs change on the same edge and carry no combinational path from inputs.
- last is registered and is exactly (step == 4*WORDS-1) whenever valid=1. It is 0 when valid=0.
- round wraps 0→1→2→3 at s wrap from WORDS-1 to 0. Step never exceeds 4*WORDS-1.

Test Plan:
- Reset, then start pulse with ready held 1 (defaults):
  - valid rises one cycle after start.
  - Expected g sequence:
    - steps 0-15: g=0..15.
    - step 16: g=1; step 17: g=6; step 31: g=12.
    - step 32: g=5; step 33: g=8.
    - step 48: g=0; step 49: g=7; step 63: g=9.
  - last high only at step 63; done pulses the cycle after step 63 is accepted; 64 valid cycles in total.
- Stall: ready=0 for 3 cycles at step 20 -> step=20, g=5, round=1 held constant; step 21 (g=10) appears one cycle after ready returns.
- Abort at step 40 with ready=1 -> valid=0 and busy=0 next cycle, done never pulses; a new start begins again at step 0, g=0.
- start asserted repeatedly during RUN -> no effect; the sequence completes normally with exactly one done pulse.
- Asynchronous reset asserted mid-cycle at step 35 -> valid, busy, done and step go to 0 immediately without waiting for a clock edge; state is IDLE after release.
- IDX_W=3 build (WORDS=8, default coefficients):
  - 32 steps; step 8 (round 1, s=0) gives g=1; step 31 (s=7) gives g=(7*7) mod 8=1.
  - done after step 31.
